// File: rtl/aes_dec_if.sv
// ---------------------------------------------------------------------------
// aes_dec_if
// Handshake/bus bundle between the receive-side datapath and the iterative
// AES-128 decryption engine.
//   anahtar         128  cipher key, sampled while key expansion runs
//   anahtar_gecerli   1  one-cycle key reload request (honoured only in IDLE)
//   sifre           128  ciphertext block
//   g_gecerli         1  ciphertext valid
//   hazir             1  engine ready to accept a block
//   blok            128  recovered plaintext (held until the next result)
//   c_gecerli         1  one-cycle plaintext valid pulse
//   hata              1  protocol error pulse (only with AES_DEC_PROTOCOL_ERR_EN)
// master = block feeding ciphertext/keys, slave = the engine.
// ---------------------------------------------------------------------------
interface aes_dec_if;
    logic [127:0] anahtar;
    logic         anahtar_gecerli;
    logic [127:0] sifre;
    logic         g_gecerli;
    logic         hazir;
    logic [127:0] blok;
    logic         c_gecerli;
`ifdef AES_DEC_PROTOCOL_ERR_EN
    logic         hata;
`endif

    modport master (
        output anahtar, anahtar_gecerli, sifre, g_gecerli,
`ifdef AES_DEC_PROTOCOL_ERR_EN
        input  hata,
`endif
        input  hazir, blok, c_gecerli
    );

    modport slave (
        input  anahtar, anahtar_gecerli, sifre, g_gecerli,
`ifdef AES_DEC_PROTOCOL_ERR_EN
        output hata,
`endif
        output hazir, blok, c_gecerli
    );
endinterface

// File: rtl/aes_decrypt_engine.sv
// ---------------------------------------------------------------------------
// aes_decrypt_engine
// Iterative AES-128 decryption, one inverse round per clock. The key schedule
// comes from keyexpansion (one round key per clock) and is applied in reverse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  aes_dec_if.slave (key, ciphertext, ready, plaintext, valid)
// Parameter OUT_REG: 1 = plaintext/valid go through one extra register.
// Optional macro AES_DEC_PROTOCOL_ERR_EN: adds bus.hata, a one-cycle pulse
// whenever g_gecerli or anahtar_gecerli is seen while the engine is busy.
// Byte order: bit 127 = byte 0 = column 0 row 0 (FIPS-197 input order).
// ---------------------------------------------------------------------------
module keyexpansion (
    input  logic          clk,
    input  logic          rst,      // active-high
    input  logic          start,    // restart expansion from key
    input  logic [127:0]  key,
    output logic [1407:0] schedule, // round key i at [1407-128*i -: 128]
    output logic          done      // one-cycle pulse after rk10 is written
);
    logic [3:0]   cnt;
    logic         busy;
    logic [7:0]   rcon;
    logic [127:0] cur;
    logic [127:0] rk [0:10];
    logic [31:0]  t;
    logic [127:0] nxt;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        return gmul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // SubWord(RotWord(w3)) ^ Rcon, then the chained word XORs
    always_comb begin
        t = {sbox(cur[23:16]), sbox(cur[15:8]), sbox(cur[7:0]), sbox(cur[31:24])}
            ^ {rcon, 24'h000000};
        nxt[127:96] = cur[127:96] ^ t;
        nxt[95:64]  = cur[95:64]  ^ nxt[127:96];
        nxt[63:32]  = cur[63:32]  ^ nxt[95:64];
        nxt[31:0]   = cur[31:0]   ^ nxt[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt  <= 4'd0;
            busy <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (cnt == 4'd0) begin
                    cur   <= key;
                    rk[0] <= key;
                    rcon  <= 8'h01;
                end else begin
                    cur     <= nxt;
                    rk[cnt] <= nxt;
                    rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
                cnt <= cnt + 4'd1;
                if (cnt == 4'd10) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 11; g++) begin : g_sched
        assign schedule[1407-128*g -: 128] = rk[g];
    end
endmodule

module aes_decrypt_engine #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    aes_dec_if.slave bus
);
    typedef enum logic [1:0] {EXPAND, IDLE, ROUND, LAST} state_t;

    state_t        state, state_nxt;
    logic [3:0]    counter;
    logic [127:0]  state_reg;
    logic [1407:0] schedule;
    logic [127:0]  rk [0:10];
    logic          kx_rst, kx_start, kx_done;
    logic          accept, hazir_c;
    logic [127:0]  inv_sr_sb, round_val, last_val;
    logic          vld_p0;
    logic [127:0]  blok_p0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        return gmul(x127, x127);
    endfunction

    // Inverse affine transform followed by field inversion
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    assign kx_rst = ~rst;

    keyexpansion u_keyexpansion (
        .clk      (clk),
        .rst      (kx_rst),
        .start    (kx_start),
        .key      (bus.anahtar),
        .schedule (schedule),
        .done     (kx_done)
    );

    for (genvar g = 0; g < 11; g++) begin : g_rk
        assign rk[g] = schedule[1407-128*g -: 128];
    end

    // Key reload wins over a same-cycle ciphertext, so hazir drops with it.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        kx_start  = 1'b0;
        hazir_c   = 1'b0;
        case (state)
            EXPAND: if (kx_done) state_nxt = IDLE;
            IDLE: begin
                hazir_c = !bus.anahtar_gecerli;
                if (bus.anahtar_gecerli) begin
                    kx_start  = 1'b1;
                    state_nxt = EXPAND;
                end else if (bus.g_gecerli) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND:   if (counter == 4'd1) state_nxt = LAST;
            LAST:    state_nxt = IDLE;
            default: state_nxt = EXPAND;
        endcase
    end

    always_comb begin
        inv_sr_sb = inv_sub(inv_shift(state_reg));
        round_val = inv_mix(inv_sr_sb ^ rk[counter]);
        last_val  = inv_sr_sb ^ rk[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EXPAND;
            counter <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                counter <= 4'd9;
            else if (state == ROUND)
                counter <= counter - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            state_reg <= bus.sifre ^ rk[10];
        else if (state == ROUND)
            state_reg <= round_val;
    end

    // ---- stage p0: result captured on the LAST edge ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            blok_p0 <= '0;
        end else begin
            vld_p0 <= (state == LAST);
            if (state == LAST)
                blok_p0 <= last_val;
        end
    end

    // ---- stage p1: optional output register ----
    if (OUT_REG) begin : g_out_reg
        logic         vld_p1;
        logic [127:0] blok_p1;
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_p1  <= 1'b0;
                blok_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0)
                    blok_p1 <= blok_p0;
            end
        end
        assign bus.blok      = blok_p1;
        assign bus.c_gecerli = vld_p1;
    end else begin : g_out_direct
        assign bus.blok      = blok_p0;
        assign bus.c_gecerli = vld_p0;
    end

    assign bus.hazir = hazir_c;

`ifdef AES_DEC_PROTOCOL_ERR_EN
    logic hata_p0;
    always_ff @(posedge clk) begin
        if (!rst)
            hata_p0 <= 1'b0;
        else
            hata_p0 <= (bus.g_gecerli || bus.anahtar_gecerli) && (state != IDLE);
    end
    assign bus.hata = hata_p0;
`endif
endmodule

// File: tb/tb_aes_decrypt_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_engine
// Directed bench for aes_decrypt_engine (OUT_REG=1) using FIPS-197 and
// SP800-38A AES-128 vectors. Edge 0 is the accept edge; outputs are sampled
// 1 time unit after each rising edge, so with OUT_REG=1 the valid pulse is
// seen after edge 11, i.e. it is sampled by edge 12.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_dec_if bus();

    aes_decrypt_engine #(.OUT_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam int LAT = 11;

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hazir(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.hazir === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Accepts one block, optionally pokes g_gecerli before edge busy_edge,
    // and watches 26 edges for valid pulses.
    task automatic decrypt(input logic [127:0] ct, input int busy_edge, output bit ok,
                           output int first, output int npulse,
                           output logic [127:0] res, output int nhata);
        first  = -1;
        npulse = 0;
        nhata  = 0;
        res    = '0;
        wait_hazir(ok);
        if (!ok) return;
        bus.sifre     = ct;
        bus.g_gecerli = 1'b1;
        tick();
        bus.g_gecerli = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            if (k == busy_edge) bus.g_gecerli = 1'b1;
            tick();
            bus.g_gecerli = 1'b0;
            if (bus.c_gecerli === 1'b1) begin
                npulse++;
                if (first < 0) begin
                    first = k;
                    res   = bus.blok;
                end
            end
`ifdef AES_DEC_PROTOCOL_ERR_EN
            if (bus.hata === 1'b1) nhata++;
`endif
        end
    endtask

    task automatic test_reset();
        rst                 = 1'b0;
        bus.anahtar         = K1;
        bus.anahtar_gecerli = 1'b0;
        bus.sifre           = '0;
        bus.g_gecerli       = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (bus.hazir !== 1'b0) begin n_err++; $display("FAIL reset_hazir: got %b want 0", bus.hazir); end
        n_vec++; if (bus.c_gecerli !== 1'b0) begin n_err++; $display("FAIL reset_c_gecerli: got %b want 0", bus.c_gecerli); end
        n_vec++; if (bus.blok !== 128'h0) begin n_err++; $display("FAIL reset_blok: got %h want 0", bus.blok); end
        rst = 1'b1;
    endtask

    task automatic test_fips_c1();
        bit ok; int first, np, nh; logic [127:0] res;
        decrypt(C1, -1, ok, first, np, res, nh);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL c1_hazir_timeout: got %b want 1", ok); end
        n_vec++; if (first !== LAT) begin n_err++; $display("FAIL c1_latency: got %0d want %0d", first, LAT); end
        n_vec++; if (np !== 1) begin n_err++; $display("FAIL c1_pulses: got %0d want 1", np); end
        n_vec++; if (res !== P1) begin n_err++; $display("FAIL c1_plaintext: got %h want %h", res, P1); end
        n_vec++; if (bus.blok !== P1) begin n_err++; $display("FAIL c1_blok_hold: got %h want %h", bus.blok, P1); end
    endtask

    task automatic test_busy_ignore();
        bit ok; int first, np, nh; logic [127:0] res;
        decrypt(C1, 4, ok, first, np, res, nh);
        n_vec++; if (first !== LAT) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", first, LAT); end
        n_vec++; if (np !== 1) begin n_err++; $display("FAIL busy_pulses: got %0d want 1", np); end
        n_vec++; if (res !== P1) begin n_err++; $display("FAIL busy_plaintext: got %h want %h", res, P1); end
`ifdef AES_DEC_PROTOCOL_ERR_EN
        n_vec++; if (nh !== 1) begin n_err++; $display("FAIL busy_hata: got %0d want 1", nh); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok; int first, np, nh, pulses; logic [127:0] res;
        wait_hazir(ok);
        bus.sifre     = C1;
        bus.g_gecerli = 1'b1;
        tick();
        bus.g_gecerli = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b0;
        tick();
        n_vec++; if (bus.hazir !== 1'b0) begin n_err++; $display("FAIL rstmid_hazir: got %b want 0", bus.hazir); end
        n_vec++; if (bus.c_gecerli !== 1'b0) begin n_err++; $display("FAIL rstmid_c_gecerli: got %b want 0", bus.c_gecerli); end
        n_vec++; if (bus.blok !== 128'h0) begin n_err++; $display("FAIL rstmid_blok: got %h want 0", bus.blok); end
        rst = 1'b1;
        pulses = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.c_gecerli === 1'b1) pulses++;
            if (bus.hazir === 1'b1) begin ok = 1'b1; break; end
        end
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_reexpand_timeout: got %b want 1", ok); end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_stray_pulse: got %0d want 0", pulses); end
        decrypt(C1, -1, ok, first, np, res, nh);
        n_vec++; if (res !== P1) begin n_err++; $display("FAIL rstmid_c1_plaintext: got %h want %h", res, P1); end
        n_vec++; if (first !== LAT) begin n_err++; $display("FAIL rstmid_c1_latency: got %0d want %0d", first, LAT); end
    endtask

    task automatic test_rekey();
        bit ok; int first, np, nh, low; logic [127:0] res;
        wait_hazir(ok);
        bus.anahtar         = K2;
        bus.anahtar_gecerli = 1'b1;
        #1;
        n_vec++; if (bus.hazir !== 1'b0) begin n_err++; $display("FAIL rekey_hazir_drop: got %b want 0", bus.hazir); end
        tick();
        bus.anahtar_gecerli = 1'b0;
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.hazir === 1'b1) begin ok = 1'b1; break; end
            low++;
            tick();
        end
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rekey_timeout: got %b want 1", ok); end
        n_vec++; if (low < 10) begin n_err++; $display("FAIL rekey_busy_cycles: got %0d want >= 10", low); end
        decrypt(C2, -1, ok, first, np, res, nh);
        n_vec++; if (res !== P2) begin n_err++; $display("FAIL rekey_plaintext: got %h want %h", res, P2); end
        n_vec++; if (np !== 1) begin n_err++; $display("FAIL rekey_pulses: got %0d want 1", np); end
    endtask

    task automatic test_back_to_back();
        bit ok, acc_now; int acc2, np; int idx [2]; logic [127:0] val [2];
        acc2 = -1; np = 0;
        idx[0] = -1; idx[1] = -1; val[0] = '0; val[1] = '0;
        wait_hazir(ok);
        bus.sifre     = C2;
        bus.g_gecerli = 1'b1;
        tick();
        bus.sifre = C3;
        for (int k = 1; k <= 30; k++) begin
            acc_now = bus.g_gecerli && (bus.hazir === 1'b1);
            tick();
            if (acc_now) begin
                acc2          = k;
                bus.g_gecerli = 1'b0;
            end
            if (bus.c_gecerli === 1'b1) begin
                if (np < 2) begin idx[np] = k; val[np] = bus.blok; end
                np++;
            end
        end
        bus.g_gecerli = 1'b0;
        n_vec++; if (acc2 !== LAT) begin n_err++; $display("FAIL b2b_second_accept: got %0d want %0d", acc2, LAT); end
        n_vec++; if (np !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", np); end
        n_vec++; if (idx[1] - idx[0] !== 11) begin n_err++; $display("FAIL b2b_spacing: got %0d want 11", idx[1] - idx[0]); end
        n_vec++; if (val[0] !== P2) begin n_err++; $display("FAIL b2b_first: got %h want %h", val[0], P2); end
        n_vec++; if (val[1] !== P3) begin n_err++; $display("FAIL b2b_second: got %h want %h", val[1], P3); end
    endtask

    task automatic test_priority();
        bit ok; int first, np, nh, pulses; logic [127:0] res;
        wait_hazir(ok);
        bus.sifre           = C2;
        bus.g_gecerli       = 1'b1;
        bus.anahtar_gecerli = 1'b1;
        #1;
        n_vec++; if (bus.hazir !== 1'b0) begin n_err++; $display("FAIL prio_hazir: got %b want 0", bus.hazir); end
        tick();
        bus.g_gecerli       = 1'b0;
        bus.anahtar_gecerli = 1'b0;
        n_vec++; if (bus.hazir !== 1'b0) begin n_err++; $display("FAIL prio_expand: got %b want 0", bus.hazir); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.c_gecerli === 1'b1) pulses++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL prio_no_output: got %0d want 0", pulses); end
        decrypt(C2, -1, ok, first, np, res, nh);
        n_vec++; if (res !== P2) begin n_err++; $display("FAIL prio_after_plaintext: got %h want %h", res, P2); end
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_busy_ignore();
        test_reset_mid();
        test_rekey();
        test_back_to_back();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_decrypt_engine.md
Name: aes_decrypt_engine

Overview:
- Iterative AES-128 decryption engine; the inverse counterpart of the team's AES encryption engine.
- Uses the same key/valid/ready port style, so a ciphertext produced by the encryptor under key K returns the original plaintext.
- Reuses the existing keyexpansion block for the 1408-bit schedule and applies the round keys in reverse.
- One inverse round per clock; sits on the receive side of the crypto datapath.

Parameters:
- OUT_REG, 1, 1 = plaintext and c_gecerli pass through one extra output register (+1 cycle latency); 0 = driven directly from the state register.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset: sampled low at a rising edge resets the block.
- anahtar  input  128  cipher key; sampled while key expansion runs.
- anahtar_gecerli  input  1  one-cycle request to re-expand anahtar; honoured only in IDLE.
- sifre  input  128  ciphertext block.
- g_gecerli  input  1  ciphertext valid.
- hazir  output  1  ready to accept a block.
- blok  output  128  recovered plaintext.
- c_gecerli  output  1  one-cycle plaintext valid pulse.

Behaviour:
- Reset (rst=0 at an edge): hazir=0, c_gecerli=0, blok=0, round counter=0, state=EXPAND.
  - Key expansion is restarted from anahtar.
  - keyexpansion gets an active-high reset, driven by ~rst.
  - Reset mid-decryption aborts the block; no c_gecerli is produced for it.
- States: EXPAND, IDLE, ROUND, LAST.
  - EXPAND -> IDLE on keyexpansion finish.
  - IDLE -> EXPAND on anahtar_gecerli.
  - IDLE -> ROUND on accept.
  - ROUND -> LAST when counter==1.
  - LAST -> IDLE.
- hazir = (state==IDLE) && !anahtar_gecerli. Key reload takes priority over a same-cycle g_gecerli, which is not accepted.
- Accept edge (g_gecerli && hazir): state_reg <= sifre ^ rk10; counter <= 9.
- ROUND edge: state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[counter])); counter decrements by 1.
  - Uses rk9 down to rk1 over 9 edges.
- LAST edge: state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk0. No InvMixColumns.
- Round key i = schedule bits [1407-128*i -: 128], so rk0 sits at the MSBs.
- Latency:
  - OUT_REG=0: c_gecerli is high in the cycle after the LAST edge, i.e. 11 edges after the accept edge, counting the accept edge as edge 0.
  - OUT_REG=1: 12 edges.
- c_gecerli is high for exactly one cycle per accepted block.
- blok holds its value until the next result; it does not return to 0 between blocks.
- hazir re-asserts in the cycle after the LAST edge, so a new block can be accepted in the same cycle c_gecerli is high (OUT_REG=0).
- g_gecerli or anahtar_gecerli while busy (ROUND, LAST or EXPAND) is ignored; no queuing.
- Byte order: bit 127 = byte 0 = state column 0, row 0 (FIPS-197 input order), identical to the encryptor.

Optional Feature:
- Macro AES_DEC_PROTOCOL_ERR_EN.
- Defined: adds output hata (1 bit, reset 0). hata pulses high for one cycle after any edge where g_gecerli=1 or anahtar_gecerli=1 was sampled while the block was not in IDLE.
- Undefined: port and logic absent; such requests are silently ignored.

Test Plan:
- FIPS-197 C.1: anahtar=000102030405060708090a0b0c0d0e0f; after hazir rises, sifre=69c4e0d86a7b0430d8cdb78070b4c55a -> blok=00112233445566778899aabbccddeeff, c_gecerli single pulse exactly 12 edges after accept (OUT_REG=1).
- Rekey: pulse anahtar_gecerli with anahtar=2b7e151628aed2a6abf7158809cf4f3c -> hazir low until finish. Then sifre=3925841d02dc09fbdc118597196a0b32 -> blok=3243f6a8885a308d313198a2e0370734.
- Back-to-back: hold g_gecerli with two ciphertexts -> second accepted the cycle hazir re-asserts, two c_gecerli pulses 11 cycles apart, both plaintexts correct.
- Busy ignore: assert g_gecerli at edge 4 of a decryption -> single correct result, no extra c_gecerli, hata pulses once (macro defined).
- Reset mid-operation: drive rst=0 at edge 5 -> next edge has hazir=0, c_gecerli=0, blok=0, no output pulse. After rst=1 and expansion finish, C.1 decrypts correctly.
- Priority: g_gecerli and anahtar_gecerli high together in IDLE -> block not accepted (hazir=0 that cycle), EXPAND entered, no c_gecerli.
